// File: rtl/multiplier_pkg.sv
// Shared constants and helpers for the iterative shift-add multiplier.
package multiplier_pkg;

    localparam int WIDTH_DEFAULT = 16;

    // Step counter must hold values 0..WIDTH.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/multiplier_core_addsub.sv
// Accumulate-step adder/subtractor. Subtraction is used only on the final
// step of a signed multiply, where the multiplier MSB carries negative weight.
module mult_addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum
);

    // Modulo-2^W add or subtract.
    always_comb begin
        sum = sub ? (x - y) : (x + y);
    end

endmodule

// File: rtl/multiplier_core.sv
// Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial product per clock; done pulses WIDTH clocks after the accept
// edge and out holds until the next completion or reset.
// Build option: MULTIPLIER_SIGNED_EN adds the is_signed input (two's
// complement operands when set, sampled on accept).
//
// state | meaning
// IDLE  | busy=0: waiting for start, out holds last product
// BUSY  | busy=1: count = partial products accumulated so far
module multiplier_core
    import multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef MULTIPLIER_SIGNED_EN
    input  logic               is_signed,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done
);

    localparam int             CW   = count_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      count;
    logic               last_step;
    logic               signed_in;
    logic               signed_q;
    logic               sext;

`ifdef MULTIPLIER_SIGNED_EN
    assign signed_in = is_signed;

    // Signedness is frozen at accept so the operand bus may change mid-op.
    always_ff @(posedge clk) begin
        if (reset)
            signed_q <= 1'b0;
        else if (start && !busy)
            signed_q <= is_signed;
    end
`else
    assign signed_in = 1'b0;
    assign signed_q  = 1'b0;
`endif

    assign sext      = signed_in & a[WIDTH-1];
    assign last_step = (count == LAST);

    mult_addsub #(
        .W (2*WIDTH)
    ) u_addsub (
        .x   (acc),
        .y   (mcand),
        .sub (last_step & signed_q),
        .sum (acc_sum)
    );

    // Partial product is taken only when the current multiplier bit is set.
    always_comb begin
        acc_next = mplier[0] ? acc_sum : acc;
    end

    // Control, operand shift registers and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            out    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (last_step) begin
                    out  <= acc_next;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                mcand  <= {{WIDTH{sext}}, a};
                mplier <= b;
                acc    <= '0;
                count  <= '0;
                busy   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_core.sv
// Scoreboard bench for multiplier_core (WIDTH=16). Stimulus pushes expected
// products and completion cycles; a monitor pops and compares on done.
module tb_multiplier_core;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] out;
    logic        busy;
    logic        done;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic        done_prev = 1'b0;

    multiplier_core #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef MULTIPLIER_SIGNED_EN
        .is_signed (is_signed),
`endif
        .a         (a),
        .b         (b),
        .out       (out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v)
            passes++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            chk("done_single_cycle", {31'd0, done_prev}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("product", out, mon_e.val);
                chk("latency", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        done_prev = done;
    end

    // Called at a negedge; accept happens at the next posedge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic sg, input logic [31:0] exp_v);
        exp_t e;
        a = ta; b = tb_v; is_signed = sg; start = 1'b1;
        e.val = exp_v;
        e.cyc = cyc + 17;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] ta, input logic [15:0] tb_v);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) chk("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int i = 0; i < 60 && !empty; i++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !busy) empty = 1'b1;
        end
        if (!empty) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int saw_done;

        // 1. reset with start held high
        reset = 1'b1; start = 1'b1; is_signed = 1'b0; a = 16'd1; b = 16'd1;
        repeat (2) @(negedge clk);
        chk("reset_out", out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);

        // 2. basic product, out holds while busy
        issue(16'hABCD, 16'h1234, 1'b0, 32'h0C374FA4);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        chk("out_held_while_busy", out, 32'd0);
        wait_done();
        chk("idle_in_done_cycle", {31'd0, busy}, 32'd0);
        drain();

        // 3. max operands, then zero operand (full latency still)
        issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        drain();
        issue(16'h0000, 16'hBEEF, 1'b0, 32'h00000000);
        drain();

        // 4. start ignored while busy; start accepted in done cycle
        issue(16'd3, 16'd5, 1'b0, 32'h0000000F);
        pulse_start(16'd7, 16'd7);
        wait_done();
        issue(16'd2, 16'd9, 1'b0, 32'h00000012);
        chk("out_held_after_done", out, 32'h0000000F);
        drain();
        chk("out_holds_when_idle", out, 32'h00000012);

        // 5. reset mid-operation aborts with no done pulse
        pulse_start(16'h1234, 16'h5678);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_out", out, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        saw_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("no_done_after_abort", 32'(saw_done), 32'd0);

`ifdef MULTIPLIER_SIGNED_EN
        // 6. signed products
        issue(16'hABCD, 16'h1234, 1'b1, 32'hFA034FA4);
        drain();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        drain();
        issue(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        drain();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
